// File: rtl/arb_mux2_pkg.sv
// arb_mux2 shared constants.
// Source indices and burst counter sizing.
package arb_mux2_pkg;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  localparam int BURST_W = 4;
  localparam logic [BURST_W-1:0] BURST_SAT = '1;

endpackage

// File: rtl/arb_rr2_grant.sv
// Two-source burst-limited round-robin grant.
// valid/last/burst_cnt in, one-hot grant out.
module arb_rr2_grant
  import arb_mux2_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic [1:0]         valid,
  input  logic               last,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic [1:0]         grant
);

  logic stay;
  logic pick;

  // burst_cnt==0 only before the first grant; the
  // reset value of last then hands source 0 the win.
  assign stay = (burst_cnt != '0) &&
                (burst_cnt < BURST_W'(MAX_BURST));

  always_comb begin
    grant = 2'b00;
    pick  = SRC0;
    unique case (1'b1)
      (valid == 2'b01): grant = 2'b01;
      (valid == 2'b10): grant = 2'b10;
      (valid == 2'b11): begin
        pick  = stay ? last : ~last;
        grant = (pick == SRC1) ? 2'b10 : 2'b01;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/arb_mux2.sv
// Two-input arbitrated mux with a registered output.
// in0/in1 valid/ready/data in; out valid/ready/data/sel.
module arb_mux2
  import arb_mux2_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  logic [1:0]         grant;
  logic [1:0]         xfer;
  logic               load;
  logic               nsel;
  logic [WIDTH-1:0]   ndata;
  logic               last;
  logic [BURST_W-1:0] burst_cnt;

  arb_rr2_grant #(
    .MAX_BURST (MAX_BURST)
  ) u_grant (
    .valid     ({in1_valid, in0_valid}),
    .last      (last),
    .burst_cnt (burst_cnt),
    .grant     (grant)
  );

  assign load = !out_valid || out_ready;

  // rst_n gates ready so nothing is accepted in reset.
  assign xfer = grant & {2{load & rst_n}};

  assign in0_ready = xfer[0];
  assign in1_ready = xfer[1];

  assign nsel  = xfer[1] ? SRC1 : SRC0;
  assign ndata = xfer[1] ? in1_data : in0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= SRC0;
      burst_cnt <= '0;
      last      <= SRC1;
    end else begin
      if (load)
        out_valid <= |xfer;
      if (|xfer) begin
        out_data <= ndata;
        out_sel  <= nsel;
        last     <= nsel;
        if (nsel != last)
          burst_cnt <= BURST_W'(1);
        else if (burst_cnt != BURST_SAT)
          burst_cnt <= burst_cnt + BURST_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_arb_mux2.sv
// Directed bench for arb_mux2.
// Vector table plus burst/backpressure/reset sequences.
module tb_arb_mux2;

  logic       clk;
  logic       rst_n;
  logic       in0_valid;
  logic [7:0] in0_data;
  logic       in0_ready;
  logic       in1_valid;
  logic [7:0] in1_data;
  logic       in1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sel;
  logic       out_ready;

  int n_cmp;
  int n_err;

  arb_mux2 #(
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (in0_ready && in1_ready) begin
      n_err++;
      $display("FAIL both_ready: in0_ready=%0b in1_ready=%0b required not both 1",
               in0_ready, in1_ready);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       i0v;
    logic [7:0] i0d;
    logic       i1v;
    logic [7:0] i1d;
    logic       ordy;
    logic       r0;
    logic       r1;
    logic       ov;
    logic [7:0] od;
    logic       sel;
  } vec_t;

  vec_t tbl [8];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] exp_seq;
    logic [7:0]  hold_d;
    logic        hold_s;

    n_cmp = 0;
    n_err = 0;

    tbl[0] = '{1, 8'hA5, 0, 8'h00, 1,  1, 0,  1, 8'hA5, 0};
    tbl[1] = '{0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h00, 0};
    tbl[2] = '{0, 8'h00, 1, 8'h3C, 0,  0, 1,  1, 8'h3C, 1};
    tbl[3] = '{1, 8'h11, 1, 8'h22, 0,  0, 0,  1, 8'h3C, 1};
    tbl[4] = '{1, 8'h11, 1, 8'h22, 1,  0, 1,  1, 8'h22, 1};
    tbl[5] = '{1, 8'h33, 0, 8'h00, 1,  1, 0,  1, 8'h33, 0};
    tbl[6] = '{0, 8'h00, 0, 8'h00, 0,  0, 0,  1, 8'h33, 0};
    tbl[7] = '{0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h00, 0};

    rst_n     = 1'b0;
    in0_valid = 1'b1;
    in0_data  = 8'hFF;
    in1_valid = 1'b1;
    in1_data  = 8'hEE;
    out_ready = 1'b1;

    #3;
    chk("rst_ov",  32'(out_valid), 32'd0);
    chk("rst_od",  32'(out_data),  32'd0);
    chk("rst_sel", 32'(out_sel),   32'd0);
    chk("rst_r0",  32'(in0_ready), 32'd0);
    chk("rst_r1",  32'(in1_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      in0_valid = tbl[i].i0v;
      in0_data  = tbl[i].i0d;
      in1_valid = tbl[i].i1v;
      in1_data  = tbl[i].i1d;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_r0", i), 32'(in0_ready), 32'(tbl[i].r0));
      chk($sformatf("v%0d_r1", i), 32'(in1_ready), 32'(tbl[i].r1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("v%0d_od", i),  32'(out_data), 32'(tbl[i].od));
        chk($sformatf("v%0d_sel", i), 32'(out_sel),  32'(tbl[i].sel));
      end
      @(negedge clk);
    end

    do_reset();
    exp_seq   = 12'b0000_1111_0000;
    in0_valid = 1'b1;
    in0_data  = 8'h10;
    in1_valid = 1'b1;
    in1_data  = 8'h20;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("burst%0d_sel", i),
          32'(out_sel), 32'(exp_seq[11-i]));
      chk($sformatf("burst%0d_od", i), 32'(out_data),
          exp_seq[11-i] ? 32'h20 : 32'h10);
    end

    @(negedge clk);
    out_ready = 1'b0;
    hold_d = out_data;
    hold_s = out_sel;
    for (int i = 0; i < 5; i++) begin
      in0_data = 8'h50 + 8'(i);
      in1_data = 8'h60 + 8'(i);
      #1;
      chk($sformatf("bp%0d_r0", i), 32'(in0_ready), 32'd0);
      chk($sformatf("bp%0d_r1", i), 32'(in1_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_ov", i),  32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_od", i),  32'(out_data),  32'(hold_d));
      chk($sformatf("bp%0d_sel", i), 32'(out_sel),   32'(hold_s));
      @(negedge clk);
    end

    out_ready = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in1_data = 8'h80 + 8'(i);
      @(posedge clk);
      #1;
      chk($sformatf("solo%0d_ov", i),  32'(out_valid), 32'd1);
      chk($sformatf("solo%0d_sel", i), 32'(out_sel),   32'd1);
      chk($sformatf("solo%0d_od", i),  32'(out_data),  32'h80 + i);
      @(negedge clk);
    end

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_r0", 32'(in0_ready), 32'd0);
    chk("arst_r1", 32'(in1_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    in0_valid = 1'b1;
    in0_data  = 8'h77;
    in1_valid = 1'b1;
    in1_data  = 8'h88;
    @(posedge clk);
    #1;
    chk("post_ov",  32'(out_valid), 32'd1);
    chk("post_sel", 32'(out_sel),   32'd0);
    chk("post_od",  32'(out_data),  32'h77);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
